ddr3_cmd_issuer: RTL and testbench

//  Host-side front end that sits directly upstream of the DDR3 processing logic.

---
 rtl/ddr3_pkg.sv | 19 +
 rtl/ddr3_cmd_issuer.sv | 103 ++++++++++
 tb/tb_ddr3_cmd_issuer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_pkg.sv
// ddr3_pkg: opcodes, command word layout and issuer FSM states shared by the DDR3 command path
package ddr3_pkg;
  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_SCR = 3'b001;
  localparam logic [2:0] OP_SCW = 3'b010;
  localparam logic [2:0] OP_ATR = 3'b011;
  localparam logic [2:0] OP_ATW = 3'b100;
  localparam int CMD_W       = 34;
  localparam int CMD_OP_HI   = 33;
  localparam int CMD_OP_LO   = 31;
  localparam int CMD_ADDR_HI = 30;
  localparam int CMD_ADDR_LO = 5;
  localparam int CMD_RSVD_HI = 4;
  localparam int CMD_RSVD_LO = 0;
  typedef enum logic [1:0] {IDLE, ISSUE_R, ISSUE_W} state_t;
  function automatic logic [CMD_W-1:0] cmd_word(input logic [2:0] op, input logic [CMD_ADDR_HI-CMD_ADDR_LO:0] addr);
    return {op, addr, 5'b00000};
  endfunction
endpackage

// File: rtl/ddr3_cmd_issuer.sv
// ddr3_cmd_issuer: expands host scalar/block requests into scalar FIFO pushes, at most one every two cycles
module ddr3_cmd_issuer
  import ddr3_pkg::*;
#(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IN_valid,
  output logic              IN_ready,
  input  logic [2:0]        IN_cmd,
  input  logic [ADDR_W-1:0] IN_addr,
  input  logic [1:0]        IN_sz,
  input  logic [DATA_W-1:0] IN_wdata,
  input  logic              IN_wvalid,
  output logic              IN_wready,
  input  logic              CMD_full,
  output logic              CMD_put,
  output logic [CMD_W-1:0]  CMD_data_in,
  input  logic              DATA_full,
  output logic              DATA_put,
  output logic [DATA_W-1:0] DATA_data_in,
  output logic              busy,
  output logic              err
);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                ph_q, ph_d;
  logic                cmd_put_q, data_put_q, err_q;
  logic [CMD_W-1:0]    cmd_data_q, cmd_data_d;
  logic [DATA_W-1:0]   data_data_q, data_data_d;
  logic                accept, is_r, is_w, is_blk, launch_r, launch_w, launch;

  assign IN_ready     = (state_q == IDLE) && !reset;
  assign IN_wready    = launch_w;
  assign busy         = state_q != IDLE;
  assign err          = err_q;
  assign CMD_put      = cmd_put_q;
  assign DATA_put     = data_put_q;
  assign CMD_data_in  = cmd_data_q;
  assign DATA_data_in = data_data_q;

  // request decode and launch conditions; ph blocks a launch in the cycle after one so full flags are current
  always_comb begin
    accept   = IN_valid && IN_ready;
    is_r     = (IN_cmd == OP_SCR) || (IN_cmd == OP_ATR);
    is_w     = (IN_cmd == OP_SCW) || (IN_cmd == OP_ATW);
    is_blk   = (IN_cmd == OP_ATR) || (IN_cmd == OP_ATW);
    launch_r = !reset && (state_q == ISSUE_R) && !ph_q && !CMD_full;
    launch_w = !reset && (state_q == ISSUE_W) && !ph_q && !CMD_full && !DATA_full && IN_wvalid;
    launch   = launch_r || launch_w;
  end

  // next state: latch a request on accept, step address/count on each launch, return idle after the last word
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    ph_d        = launch;
    cmd_data_d  = cmd_data_q;
    data_data_d = data_data_q;
    if (accept && (is_r || is_w)) begin
      state_d = is_r ? ISSUE_R : ISSUE_W;
      addr_d  = IN_addr;
      rem_d   = is_blk ? CNT_W'(1) << IN_sz : CNT_W'(1);
    end
    if (launch) begin
      state_d    = (rem_q == CNT_W'(1)) ? IDLE : state_q;
      addr_d     = addr_q + ADDR_W'(1);
      rem_d      = rem_q - CNT_W'(1);
      cmd_data_d = {launch_w ? OP_SCW : OP_SCR, addr_q, 5'b00000};
    end
    data_data_d = launch_w ? IN_wdata : data_data_q;
  end

  // state and registered output pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      ph_q        <= 1'b0;
      cmd_put_q   <= 1'b0;
      data_put_q  <= 1'b0;
      err_q       <= 1'b0;
      cmd_data_q  <= '0;
      data_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      ph_q        <= ph_d;
      cmd_put_q   <= launch;
      data_put_q  <= launch_w;
      err_q       <= accept && (IN_cmd > OP_ATW);
      cmd_data_q  <= cmd_data_d;
      data_data_q <= data_data_d;
    end
  end
endmodule

// File: tb/tb_ddr3_cmd_issuer.sv
// tb_ddr3_cmd_issuer: directed requests against a queue model of the expected push sequence
module tb_ddr3_cmd_issuer;
  logic        clk = 0, reset = 1;
  logic        IN_valid = 0, IN_ready, IN_wvalid = 0, IN_wready;
  logic [2:0]  IN_cmd = 0;
  logic [25:0] IN_addr = 0;
  logic [1:0]  IN_sz = 0;
  logic [15:0] IN_wdata = 0;
  logic        CMD_full = 0, CMD_put, DATA_full = 0, DATA_put, busy, err;
  logic [33:0] CMD_data_in;
  logic [15:0] DATA_data_in;

  int pass_cnt = 0, total = 0, put_cnt = 0, wr_cnt = 0, err_cnt = 0, cyc = 0, last_put_cyc = 0;
  logic [33:0] last_cmd;
  logic [15:0] last_data;
  logic        err_due = 0;
  logic [33:0] exp_cmd[$];
  logic        exp_hasd[$];
  logic [15:0] exp_data[$];
  logic [15:0] wbuf[8];

  ddr3_cmd_issuer dut (
    .clk(clk), .reset(reset), .IN_valid(IN_valid), .IN_ready(IN_ready), .IN_cmd(IN_cmd),
    .IN_addr(IN_addr), .IN_sz(IN_sz), .IN_wdata(IN_wdata), .IN_wvalid(IN_wvalid),
    .IN_wready(IN_wready), .CMD_full(CMD_full), .CMD_put(CMD_put), .CMD_data_in(CMD_data_in),
    .DATA_full(DATA_full), .DATA_put(DATA_put), .DATA_data_in(DATA_data_in), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h want=%0h", nm, got, exp);
  endtask

  // per-cycle compare against the model queue
  always begin
    logic [33:0] e;
    logic        eh;
    logic [15:0] ed;
    @(negedge clk); #2;
    cyc++;
    if (CMD_put) begin
      put_cnt++;
      last_cmd  = CMD_data_in;
      last_data = DATA_data_in;
      if (exp_cmd.size() == 0) chk("put_when_none_expected", CMD_put, 0);
      else begin
        e = exp_cmd.pop_front(); eh = exp_hasd.pop_front(); ed = exp_data.pop_front();
        chk("cmd_word", CMD_data_in, e);
        chk("data_put_pairing", DATA_put, eh);
        if (eh) chk("data_word", DATA_data_in, ed);
      end
      if (put_cnt > 1) chk("put_spacing_ge2", (cyc - last_put_cyc) >= 2, 1);
      last_put_cyc = cyc;
    end else chk("data_put_without_cmd", DATA_put, 0);
    chk("busy", busy, exp_cmd.size() != 0);
    chk("err", err, err_due);
    if (err) err_cnt++;
    err_due = 0;
    if (IN_wready) begin
      wr_cnt++;
      chk("wready_needs_wvalid", IN_wvalid, 1);
    end
  end

  task automatic req(input logic [2:0] c, input logic [25:0] a, input logic [1:0] s);
    int n;
    int words;
    logic [2:0] op;
    n = 0;
    @(negedge clk);
    IN_valid = 1; IN_cmd = c; IN_addr = a; IN_sz = s;
    #1;
    while (!IN_ready && n < 100) begin @(negedge clk); #1; n++; end
    chk("accept_timeout", IN_ready, 1);
    @(posedge clk);
    if (c >= 3'b001 && c <= 3'b100) begin
      words = (c == 3'b011 || c == 3'b100) ? (1 << s) : 1;
      op = (c == 3'b010 || c == 3'b100) ? 3'b010 : 3'b001;
      for (int i = 0; i < words; i++) begin
        exp_cmd.push_back({op, a + 26'(i), 5'b00000});
        exp_hasd.push_back(op == 3'b010);
        exp_data.push_back(wbuf[i]);
      end
    end
    if (c > 3'b100) err_due = 1;
    @(negedge clk);
    IN_valid = 0; IN_cmd = 0;
  endtask

  task automatic send_words(input int n, input int gap);
    int t;
    for (int i = 0; i < n; i++) begin
      IN_wvalid = 1; IN_wdata = wbuf[i]; t = 0;
      #1;
      while (!IN_wready && t < 100) begin @(negedge clk); #1; t++; end
      chk("wready_timeout", IN_wready, 1);
      @(negedge clk);
      IN_wvalid = 0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    #3;
    while ((exp_cmd.size() != 0 || busy) && t < 300) begin @(negedge clk); #3; t++; end
    chk("idle_timeout", exp_cmd.size(), 0);
  endtask

  initial begin
    int base, t;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", IN_ready, 0);
    chk("rst_cmd_put", CMD_put, 0);
    chk("rst_cmd_data", CMD_data_in, 0);
    chk("rst_data_data", DATA_data_in, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk); reset = 0; #1;
    chk("in_ready_after_rst", IN_ready, 1);

    // 1: scalar read
    base = put_cnt;
    req(3'b001, 26'h0001234, 2'd0);
    wait_idle();
    chk("t1_put_count", put_cnt - base, 1);
    chk("t1_cmd_literal", last_cmd, 34'h0_8002_4680);
    chk("t1_in_ready_after", IN_ready, 1);

    // 2: 4-word write wrapping the address space
    wbuf[0] = 16'h00A1; wbuf[1] = 16'h00B2; wbuf[2] = 16'h00C3; wbuf[3] = 16'h00D4;
    base = put_cnt;
    req(3'b100, 26'h3FFFFFE, 2'd2);
    send_words(4, 0);
    wait_idle();
    chk("t2_put_count", put_cnt - base, 4);
    chk("t2_last_cmd", last_cmd, 34'h1_0000_0020);
    chk("t2_last_data", last_data, 16'h00D4);

    // 3: 8-word read stalled by CMD_full after the 3rd put
    base = put_cnt; t = 0;
    req(3'b011, 26'h0000100, 2'd3);
    while (put_cnt < base + 3 && t < 100) begin @(negedge clk); #3; t++; end
    chk("t3_third_put_timeout", put_cnt - base, 3);
    CMD_full = 1;
    repeat (10) @(negedge clk);
    #3;
    chk("t3_no_put_in_stall", put_cnt - base, 3);
    CMD_full = 0;
    wait_idle();
    chk("t3_put_count", put_cnt - base, 8);
    chk("t3_last_cmd", last_cmd, 34'h0_8000_20E0);

    // 4: 2-word write with wvalid gaps
    wbuf[0] = 16'h1111; wbuf[1] = 16'h2222;
    base = put_cnt; t = wr_cnt;
    req(3'b100, 26'h0000040, 2'd1);
    repeat (3) @(negedge clk);
    send_words(2, 6);
    wait_idle();
    chk("t4_put_count", put_cnt - base, 2);
    chk("t4_wready_cycles", wr_cnt - t, 2);
    chk("t4_last_data", last_data, 16'h2222);

    // 5: illegal opcode
    base = put_cnt; t = err_cnt;
    req(3'b111, 26'h0000055, 2'd0);
    repeat (4) @(negedge clk);
    chk("t5_err_pulses", err_cnt - t, 1);
    chk("t5_no_put", put_cnt - base, 0);

    // 6: reset mid-burst after the 2nd put
    for (int i = 0; i < 8; i++) wbuf[i] = 16'h5A00 + 16'(i);
    base = put_cnt;
    req(3'b100, 26'h0000200, 2'd3);
    send_words(2, 0);
    #3;
    chk("t6_puts_before_reset", put_cnt - base, 2);
    reset = 1;
    @(posedge clk);
    exp_cmd.delete(); exp_hasd.delete(); exp_data.delete();
    #1;
    chk("t6_rst_in_ready", IN_ready, 0);
    chk("t6_rst_cmd_data", CMD_data_in, 0);
    chk("t6_rst_data_data", DATA_data_in, 0);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk); reset = 0; #1;
    chk("t6_in_ready_after_rst", IN_ready, 1);
    base = put_cnt;
    repeat (20) @(negedge clk);
    #3;
    chk("t6_no_put_after_rst", put_cnt - base, 0);

    // scalar write after reset recovery
    wbuf[0] = 16'hBEEF;
    base = put_cnt;
    req(3'b010, 26'h2ABCDEF, 2'd3);
    send_words(1, 0);
    wait_idle();
    chk("t7_put_count", put_cnt - base, 1);
    chk("t7_cmd_literal", last_cmd, 34'h1_5579_BDE0);
    chk("t7_data", last_data, 16'hBEEF);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
